ara_pe_insn_queue: RTL and testbench

//  Receiving end of the sequencer->PE request bus. One instance sits in front of each PE
//  (lane VFU group, load, store, slide or mask unit). It accepts the broadcast vector

---
 rtl/ara_pkg.sv | 56 +++++
 rtl/ara_pe_insn_queue.sv | 142 ++++++++++++++
 tb/tb_ara_pe_insn_queue.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared Ara types for the sequencer->PE request bus
//
// Purpose: vector-instruction id, VFU encoding, request/response structs and
// the per-PE VFU acceptance mask used by the PE instruction queues.
// Ports: none (package).

package ara_pkg;

  localparam int unsigned NrVInsn = 8;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [2:0] {
    VFU_None      = 3'd0,
    VFU_Alu       = 3'd1,
    VFU_MFpu      = 3'd2,
    VFU_SlideUnit = 3'd3,
    VFU_MaskUnit  = 3'd4,
    VFU_LoadUnit  = 3'd5,
    VFU_StoreUnit = 3'd6
  } vfu_e;

  // One bit per encodable vfu_e value, so any vfu field indexes the mask safely.
  localparam int unsigned NrVfuCodes = 8;
  typedef logic [NrVfuCodes-1:0] vfu_mask_t;

  localparam int unsigned DefaultQueueDepth = 4;

  typedef struct packed {
    vid_t               id;
    vfu_e               vfu;
    logic [5:0]         op;
    logic [15:0]        vl;
    logic [NrVInsn-1:0] hazard_vs1;
    logic [NrVInsn-1:0] hazard_vs2;
    logic [NrVInsn-1:0] hazard_vd;
    logic [NrVInsn-1:0] hazard_vm;
    logic [NrVInsn-1:0] vinsn_running;
  } pe_req_t;

  typedef struct packed {
    logic [NrVInsn-1:0] vinsn_done;
  } pe_resp_t;

  // A hazard on an instruction that is no longer running can never come back.
  function automatic pe_req_t mask_hazards(pe_req_t req, logic [NrVInsn-1:0] running);
    pe_req_t r;
    r            = req;
    r.hazard_vs1 = req.hazard_vs1 & running;
    r.hazard_vs2 = req.hazard_vs2 & running;
    r.hazard_vd  = req.hazard_vd  & running;
    r.hazard_vm  = req.hazard_vm  & running;
    return r;
  endfunction

endpackage

// File: rtl/ara_pe_insn_queue.sv
// rtl/ara_pe_insn_queue.sv - per-PE in-order vector instruction queue with hazard gating
//
// Purpose: accepts broadcast requests addressed to this PE's VFUs, buffers them
// in order, masks their hazards every cycle with the running vector, issues the
// head once hazard-free and returns registered one-hot completion pulses.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pe_req_i/_valid_i        broadcast request (vinsn_running valid every cycle)
//   pe_req_ready_o           this PE ready (combinational from pe_req_i and state)
//   pe_resp_o                vinsn_done completion pulses
//   exec_req_o/_valid_o      head instruction to the execution unit
//   exec_ready_i             execution unit takes the head
//   exec_done_i              ids finished by the unit this cycle

module ara_pe_insn_queue import ara_pkg::*; #(
  parameter int unsigned QueueDepth = DefaultQueueDepth,
  parameter vfu_mask_t   VfuMask    = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  pe_req_t            pe_req_i,
  input  logic               pe_req_valid_i,
  output logic               pe_req_ready_o,
  output pe_resp_t           pe_resp_o,
  output pe_req_t            exec_req_o,
  output logic               exec_valid_o,
  input  logic               exec_ready_i,
  input  logic [NrVInsn-1:0] exec_done_i
);

  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW = $clog2(QueueDepth + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  pe_req_t            entries_q [QueueDepth];
  logic [QueueDepth-1:0] slot_valid_q;
  ptr_t               wr_ptr_q, rd_ptr_q;
  cnt_t               count_q;
  logic [NrVInsn-1:0] pending_q;
  logic               acked_valid_q;
  vid_t               acked_id_q;
  pe_resp_t           resp_q;

  logic               full, empty, targeted, dup, enq, pop, head_blocked;
  pe_req_t            head;
  logic [NrVInsn-1:0] done_eff, pop_onehot, queued_ids;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(QueueDepth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full     = (count_q == cnt_t'(QueueDepth));
  assign empty    = (count_q == '0);
  assign targeted = VfuMask[pe_req_i.vfu];

  // Readiness deliberately ignores a same-cycle pop: no exec_ready_i -> pe_req_ready_o path.
  assign pe_req_ready_o = !full || !targeted;

  // The sequencer keeps a request up until every PE is ready; only the first cycle counts.
  assign dup = acked_valid_q && (pe_req_i.id == acked_id_q);
  assign enq = pe_req_valid_i && targeted && !full && !dup;

  assign head         = entries_q[rd_ptr_q];
  assign head_blocked = |{head.hazard_vs1, head.hazard_vs2, head.hazard_vd, head.hazard_vm};
  assign exec_valid_o = !empty && !head_blocked;
  assign exec_req_o   = empty ? '0 : head;
  assign pop          = exec_valid_o && exec_ready_i;

  // Done for an id that was never handed out is dropped here.
  assign done_eff   = exec_done_i & pending_q;
  assign pop_onehot = pop ? ({{(NrVInsn-1){1'b0}}, 1'b1} << head.id) : '0;

  assign pe_resp_o = resp_q;

  always_comb begin
    queued_ids = '0;
    for (int unsigned i = 0; i < QueueDepth; i++) begin
      if (slot_valid_q[i]) queued_ids[entries_q[i].id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < QueueDepth; i++) entries_q[i] <= '0;
      slot_valid_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pending_q     <= '0;
      acked_valid_q <= 1'b0;
      acked_id_q    <= '0;
      resp_q        <= '0;
    end else begin
      // Entries are rewritten in place, which is why storage is not a generic FIFO.
      for (int unsigned i = 0; i < QueueDepth; i++) begin
        entries_q[i] <= mask_hazards(entries_q[i], pe_req_i.vinsn_running);
      end

      // Write slot is free whenever enq is set, so this overrides the masking above.
      if (enq) begin
        entries_q[wr_ptr_q]    <= mask_hazards(pe_req_i, pe_req_i.vinsn_running);
        slot_valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end

      if (pop) begin
        slot_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q               <= ptr_inc(rd_ptr_q);
      end

      if (enq && !pop)      count_q <= count_q + cnt_t'(1);
      else if (!enq && pop) count_q <= count_q - cnt_t'(1);

      pending_q         <= (pending_q & ~done_eff) | pop_onehot;
      resp_q.vinsn_done <= done_eff;

      if (!pe_req_valid_i) begin
        acked_valid_q <= 1'b0;
      end else if (enq) begin
        acked_valid_q <= 1'b1;
        acked_id_q    <= pe_req_i.id;
      end else if (acked_valid_q && done_eff[acked_id_q]) begin
        acked_valid_q <= 1'b0;
      end
    end
  end

  enq_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni) enq |-> !full);

  // An id being completed in the same cycle may legally be re-enqueued.
  enq_id_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
    enq |-> (!queued_ids[pe_req_i.id] && !(pending_q[pe_req_i.id] && !exec_done_i[pe_req_i.id])));

  ready_without_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !exec_valid_o |-> !pop);

  pop_done_same_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> !exec_done_i[head.id]);

endmodule

// File: tb/tb_ara_pe_insn_queue.sv
// tb/tb_ara_pe_insn_queue.sv - directed and randomized checks of ara_pe_insn_queue
module tb_ara_pe_insn_queue;
  import ara_pkg::*;

  localparam int unsigned Depth = 4;
  localparam vfu_mask_t   Mask  = 8'b0000_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  pe_req_t     pe_req;
  logic        pe_req_valid;
  logic        pe_req_ready;
  pe_resp_t    pe_resp;
  pe_req_t     exec_req;
  logic        exec_valid;
  logic        exec_ready;
  logic [7:0]  exec_done;

  always #5 clk = ~clk;

  ara_pe_insn_queue #(.QueueDepth(Depth), .VfuMask(Mask)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pe_req_i(pe_req), .pe_req_valid_i(pe_req_valid), .pe_req_ready_o(pe_req_ready),
    .pe_resp_o(pe_resp),
    .exec_req_o(exec_req), .exec_valid_o(exec_valid), .exec_ready_i(exec_ready),
    .exec_done_i(exec_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk1(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkr(string tag, pe_req_t obs, pe_req_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: an ordered list of buffered instructions plus id bookkeeping.
  pe_req_t    mq[$];
  logic [7:0] m_pend, m_resp;
  bit         m_ackv;
  vid_t       m_ackid;
  vid_t       issued[$];

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    return (mq[0].hazard_vs1 | mq[0].hazard_vs2 | mq[0].hazard_vd | mq[0].hazard_vm) == 8'h00;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < Depth) || !Mask[pe_req.vfu];
  endfunction

  function automatic logic [7:0] m_queued();
    logic [7:0] q = 8'h00;
    foreach (mq[i]) q[mq[i].id] = 1'b1;
    return q;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pend = 8'h00;
    m_resp = 8'h00;
    m_ackv = 1'b0;
    m_ackid = '0;
  endtask

  task automatic sample();
    @(negedge clk);
    chk1("ready", pe_req_ready, m_ready());
    chk1("exec_valid", exec_valid, m_valid());
    if (m_valid()) chkr("exec_req", exec_req, mq[0]);
    chk8("vinsn_done", pe_resp.vinsn_done, m_resp);
    if (exec_valid === 1'b1 && exec_ready) issued.push_back(exec_req.id);
  endtask

  task automatic advance();
    bit         tg, en, pp;
    logic [7:0] de, newp, one;
    pe_req_t    r;
    @(posedge clk);
    one  = 8'h01;
    tg   = Mask[pe_req.vfu];
    en   = pe_req_valid && tg && (mq.size() < Depth) && !(m_ackv && pe_req.id == m_ackid);
    pp   = m_valid() && exec_ready;
    de   = exec_done & m_pend;
    newp = pp ? (one << mq[0].id) : 8'h00;
    m_resp = de;
    m_pend = (m_pend & ~de) | newp;
    if (pp) void'(mq.pop_front());
    foreach (mq[i]) begin
      mq[i].hazard_vs1 &= pe_req.vinsn_running;
      mq[i].hazard_vs2 &= pe_req.vinsn_running;
      mq[i].hazard_vd  &= pe_req.vinsn_running;
      mq[i].hazard_vm  &= pe_req.vinsn_running;
    end
    if (en) begin
      r = pe_req;
      r.hazard_vs1 &= pe_req.vinsn_running;
      r.hazard_vs2 &= pe_req.vinsn_running;
      r.hazard_vd  &= pe_req.vinsn_running;
      r.hazard_vm  &= pe_req.vinsn_running;
      mq.push_back(r);
    end
    if (!pe_req_valid) m_ackv = 1'b0;
    else if (en) begin
      m_ackv = 1'b1;
      m_ackid = pe_req.id;
    end else if (m_ackv && de[m_ackid]) m_ackv = 1'b0;
    #1;
  endtask

  task automatic set_req(int id, vfu_e v, logic [7:0] h1, logic [7:0] h2, logic [7:0] hd, logic [7:0] hm);
    pe_req_t r = '0;
    r.id = vid_t'(id);
    r.vfu = v;
    r.op = 6'($urandom());
    r.vl = 16'($urandom());
    r.hazard_vs1 = h1;
    r.hazard_vs2 = h2;
    r.hazard_vd = hd;
    r.hazard_vm = hm;
    r.vinsn_running = pe_req.vinsn_running;
    pe_req = r;
  endtask

  initial begin
    int   hold;
    bit   accepted;
    logic [7:0] free;
    int   pick;
    vfu_e v;
    vid_t exp_id;

    rst_n = 1'b0;
    pe_req = '0;
    pe_req_valid = 1'b0;
    exec_ready = 1'b0;
    exec_done = 8'h00;
    m_reset();
    #1;
    chk1("rst_ready", pe_req_ready, 1'b1);
    chk1("rst_valid", exec_valid, 1'b0);
    chkr("rst_req", exec_req, '0);
    chk8("rst_done", pe_resp.vinsn_done, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: issue at t+1, done at t+5 reported at t+6 for one cycle.
    set_req(3, VFU_Alu, 0, 0, 0, 0);
    pe_req_valid = 1'b1;
    exec_ready = 1'b1;
    sample(); chk1("t1_valid_t0", exec_valid, 1'b0); advance();
    pe_req_valid = 1'b0;
    sample(); chk1("t1_valid_t1", exec_valid, 1'b1); chk8("t1_id", 8'(exec_req.id), 8'd3); advance();
    repeat (3) begin sample(); advance(); end
    exec_done = 8'h08;
    sample(); advance();
    exec_done = 8'h00;
    sample(); chk8("t1_done_t6", pe_resp.vinsn_done, 8'h08); advance();
    sample(); chk8("t1_done_t7", pe_resp.vinsn_done, 8'h00); advance();

    // Non-targeted request is only acknowledged.
    set_req(5, VFU_LoadUnit, 0, 0, 0, 0);
    pe_req_valid = 1'b1;
    sample(); chk1("t2_ready", pe_req_ready, 1'b1); advance();
    pe_req_valid = 1'b0;
    sample(); chk1("t2_valid", exec_valid, 1'b0); advance();

    // Held request enqueued once; a different id right after is enqueued too.
    exec_ready = 1'b0;
    set_req(2, VFU_Alu, 0, 0, 0, 0);
    pe_req_valid = 1'b1;
    repeat (3) begin sample(); advance(); end
    set_req(4, VFU_Alu, 0, 0, 0, 0);
    sample(); advance();
    pe_req_valid = 1'b0;
    sample(); chk8("t3_head0", 8'(exec_req.id), 8'd2);
    exec_ready = 1'b1;
    advance();
    sample(); chk1("t3_valid1", exec_valid, 1'b1); chk8("t3_head1", 8'(exec_req.id), 8'd4); advance();
    sample(); chk1("t3_empty", exec_valid, 1'b0);
    exec_ready = 1'b0;
    exec_done = 8'h14;
    advance();
    exec_done = 8'h00;
    sample(); chk8("t3_done", pe_resp.vinsn_done, 8'h14); advance();

    // Head hazard blocks until its producer stops running.
    exec_ready = 1'b1;
    pe_req.vinsn_running = 8'h01;
    set_req(1, VFU_Alu, 8'h01, 0, 0, 0);
    pe_req_valid = 1'b1;
    sample(); advance();
    pe_req_valid = 1'b0;
    repeat (4) begin sample(); chk1("t4_blocked", exec_valid, 1'b0); advance(); end
    pe_req.vinsn_running = 8'h00;
    sample(); chk1("t4_still_blocked", exec_valid, 1'b0); advance();
    sample(); chk1("t4_released", exec_valid, 1'b1); chk8("t4_vs1", exec_req.hazard_vs1, 8'h00); advance();
    exec_ready = 1'b0;
    exec_done = 8'h02;
    sample(); advance();
    exec_done = 8'h00;
    sample(); chk8("t4_done", pe_resp.vinsn_done, 8'h02); advance();

    // Full queue back-pressure and in-order issue.
    issued.delete();
    pe_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(i, VFU_Alu, 0, 0, 0, 0);
      sample(); advance();
    end
    set_req(4, VFU_Alu, 0, 0, 0, 0);
    sample(); chk1("t5_full_ready", pe_req_ready, 1'b0); advance();
    exec_ready = 1'b1;
    sample(); chk1("t5_full_pop_ready", pe_req_ready, 1'b0); advance();
    sample(); chk1("t5_freed_ready", pe_req_ready, 1'b1); advance();
    pe_req_valid = 1'b0;
    repeat (6) begin sample(); advance(); end
    chk8("t5_count", 8'(issued.size()), 8'd5);
    for (int i = 0; i < 5; i++) begin
      exp_id = vid_t'(i);
      chk8("t5_order", (i < issued.size()) ? 8'(issued[i]) : 8'hFF, 8'(exp_id));
    end
    exec_ready = 1'b0;
    exec_done = 8'h1F;
    sample(); advance();
    exec_done = 8'h00;
    sample(); chk8("t5_done", pe_resp.vinsn_done, 8'h1F); advance();

    // Randomized traffic against the model.
    accepted = 1'b0;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      exec_done = m_pend & 8'($urandom());
      pe_req.vinsn_running = 8'($urandom() & $urandom() & $urandom());
      exec_ready = ($urandom_range(0, 3) != 0);
      if (pe_req_valid && !accepted) begin
        // must keep presenting the same request
      end else if (pe_req_valid && hold > 0) begin
        hold--;
      end else if ($urandom_range(0, 3) == 0) begin
        pe_req_valid = 1'b0;
      end else begin
        free = ~(m_queued() | m_pend);
        if (m_ackv) free[m_ackid] = 1'b0;
        if (free == 8'h00) begin
          pe_req_valid = 1'b0;
        end else begin
          pick = $urandom_range(0, 7);
          while (!free[pick[2:0]]) pick = (pick + 1) % 8;
          case ($urandom_range(0, 5))
            3: v = VFU_LoadUnit;
            4: v = VFU_StoreUnit;
            5: v = VFU_SlideUnit;
            default: v = VFU_Alu;
          endcase
          set_req(pick, v, 8'($urandom() & $urandom() & $urandom()), 8'($urandom() & $urandom() & $urandom()),
                  8'($urandom() & $urandom() & $urandom()), 8'($urandom() & $urandom() & $urandom()));
          pe_req_valid = 1'b1;
          accepted = 1'b0;
          hold = $urandom_range(0, 2);
        end
      end
      sample();
      if (pe_req_valid && m_ready()) accepted = 1'b1;
      advance();
    end

    // Drain everything before the reset scenario.
    pe_req_valid = 1'b0;
    pe_req.vinsn_running = 8'h00;
    exec_ready = 1'b1;
    repeat (20) begin
      exec_done = m_pend;
      sample(); advance();
    end
    exec_done = 8'h00;
    sample(); chk1("drain_empty", exec_valid, 1'b0); advance();

    // Reset with two queued and one pending instruction.
    exec_ready = 1'b0;
    pe_req_valid = 1'b1;
    for (int i = 5; i < 8; i++) begin
      set_req(i, VFU_Alu, 0, 0, 0, 0);
      sample(); advance();
    end
    pe_req_valid = 1'b0;
    exec_ready = 1'b1;
    sample(); advance();
    exec_ready = 1'b0;
    sample(); chk8("t6_head", 8'(exec_req.id), 8'd6);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_ready", pe_req_ready, 1'b1);
    chk1("t6_rst_valid", exec_valid, 1'b0);
    chkr("t6_rst_req", exec_req, '0);
    chk8("t6_rst_done", pe_resp.vinsn_done, 8'h00);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exec_done = 8'h20;
    sample(); advance();
    exec_done = 8'h00;
    sample(); chk8("t6_stale_done", pe_resp.vinsn_done, 8'h00); chk1("t6_after_valid", exec_valid, 1'b0); advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
